// File: rtl/code_loader_if.sv
// Bundle of the byte-stream, instruction-RAM and status signals of the code loader.
// The master side feeds bytes; the slave side (the loader) drives RAM writes and status.
interface code_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  // Handshake: a byte moves on any rising edge where rx_valid && rx_ready; the source
  // may hold rx_valid low for any number of cycles, and rx_ready depends only on state.
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, ram_we, ram_addr, ram_wdata, core_hold, busy, done, err, state_dbg
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, ram_we, ram_addr, ram_wdata, core_hold, busy, done, err, state_dbg
  );
endinterface

// File: rtl/code_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes it as
// little-endian 32-bit words into instruction RAM while holding the core in reset.
module code_loader (
  input  logic          sys_clk,
  input  logic          sys_res_n,
  code_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [12:0] last_idx_q;
  logic [12:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic [7:0]  csum_q;
  logic        we_q;
  logic [12:0] addr_q;
  logic [31:0] wdata_q;
  logic        hold_q;
  logic        done_q;
  logic        err_q;

  logic        accept;
  logic [15:0] len_word;
  logic [15:0] len_m1;
  logic        len_bad;
  logic        last_byte;
  logic        last_word;
  logic [7:0]  csum_final;

  assign accept     = bus.rx_valid && (state_q != IDLE);
  assign len_word   = {bus.rx_data, len_lo_q};
  assign len_m1     = len_word - 16'd1;
  assign len_bad    = (len_word == 16'd0) || (len_word > 16'd8192);
  assign last_byte  = (byte_cnt_q == 2'd3);
  assign last_word  = (word_idx_q == last_idx_q);
  assign csum_final = csum_q + bus.rx_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LEN0;
      LEN0: if (accept) state_d = LEN1;
      LEN1: if (accept) state_d = len_bad ? IDLE : DATA;
      DATA: if (accept && last_byte && last_word) state_d = CHK;
      CHK:  if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      len_lo_q   <= '0;
      last_idx_q <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
          end
        end
        LEN0: if (accept) len_lo_q <= bus.rx_data;
        LEN1: begin
          if (accept) begin
            if (len_bad) err_q <= 1'b1;
            else         last_idx_q <= len_m1[12:0];
          end
        end
        DATA: begin
          if (accept) begin
            csum_q     <= csum_q + bus.rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Bytes shift in from the top so the first byte ends up in the low lane.
            if (last_byte) begin
              we_q    <= 1'b1;
              addr_q  <= word_idx_q;
              wdata_q <= {bus.rx_data, asm_q};
              if (!last_word) word_idx_q <= word_idx_q + 13'd1;
            end else begin
              asm_q <= {bus.rx_data, asm_q[23:8]};
            end
          end
        end
        CHK: begin
          if (accept) begin
            if (csum_final == 8'h00) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
              err_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = (state_q != IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: byte-stream driver, RAM-write scoreboard,
// directed sessions for good/bad checksum, bad lengths, gaps, full size and reset abort.
module tb_code_loader;

  logic sys_clk;
  logic sys_res_n;
  code_loader_if ifc();

  code_loader dut (
    .sys_clk   (sys_clk),
    .sys_res_n (sys_res_n),
    .bus       (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [12:0] last_addr = '0;
  logic [44:0] exp_q[$];
  logic [31:0] payload[$];

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every RAM write must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (ifc.done) done_cnt++;
    if (ifc.ram_we) begin
      we_cnt++;
      last_addr = ifc.ram_addr;
      if (exp_q.size() == 0) begin
        check("we_unexpected", {63'd0, ifc.ram_we}, 64'd0);
      end else begin
        logic [44:0] e;
        e = exp_q.pop_front();
        check("ram_write", {19'd0, ifc.ram_addr, ifc.ram_wdata}, {19'd0, e});
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_session();
    ifc.start = 1'b1;
    cycle();
    ifc.start = 1'b0;
    check("start_busy", {63'd0, ifc.busy}, 64'd1);
    check("start_err_clr", {63'd0, ifc.err}, 64'd0);
    check("start_hold", {63'd0, ifc.core_hold}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit stray);
    int t;
    for (int g = 0; g < gap; g++) begin
      ifc.rx_valid = 1'b0;
      ifc.start = stray;
      cycle();
    end
    ifc.rx_valid = 1'b1;
    ifc.rx_data = b;
    ifc.start = stray;
    t = 0;
    while (!ifc.rx_ready && t < 50) begin
      cycle();
      t++;
    end
    if (!ifc.rx_ready) check("rx_ready_wait", {63'd0, ifc.rx_ready}, 64'd1);
    cycle();
    ifc.rx_valid = 1'b0;
    ifc.start = 1'b0;
  endtask

  // Sends the words in payload; bad selects a checksum byte of 00 (nonzero sum).
  task automatic load(input string tag, input int max_gap, input bit bad, input bit stray);
    int n, we0, done0;
    logic [7:0] sum, b;
    logic [12:0] a;
    n = payload.size();
    we0 = we_cnt;
    done0 = done_cnt;
    sum = 8'h00;
    start_session();
    send_byte(n[7:0], $urandom_range(0, max_gap), stray);
    send_byte(n[15:8], $urandom_range(0, max_gap), stray);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = payload[i][8*k +: 8];
        sum = sum + b;
        if (k == 3) begin
          a = 13'(i);
          exp_q.push_back({a, payload[i]});
        end
        send_byte(b, $urandom_range(0, max_gap), stray);
      end
    end
    send_byte(bad ? 8'h00 : (8'h00 - sum), $urandom_range(0, max_gap), stray);
    cycle();
    cycle();
    check({tag, "_we_cnt"}, 64'(we_cnt - we0), 64'(n));
    check({tag, "_done"}, 64'(done_cnt - done0), bad ? 64'd0 : 64'd1);
    check({tag, "_err"}, {63'd0, ifc.err}, bad ? 64'd1 : 64'd0);
    check({tag, "_hold"}, {63'd0, ifc.core_hold}, bad ? 64'd1 : 64'd0);
    check({tag, "_busy"}, {63'd0, ifc.busy}, 64'd0);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bad_length(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    int we0;
    we0 = we_cnt;
    start_session();
    send_byte(lo, 0, 1'b0);
    send_byte(hi, 0, 1'b0);
    cycle();
    check({tag, "_err"}, {63'd0, ifc.err}, 64'd1);
    check({tag, "_state"}, {61'd0, ifc.state_dbg}, 64'd0);
    check({tag, "_hold"}, {63'd0, ifc.core_hold}, 64'd1);
    check({tag, "_we_cnt"}, 64'(we_cnt - we0), 64'd0);
  endtask

  function automatic logic [63:0] reset_view();
    return {10'd0, ifc.rx_ready, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata,
            ifc.core_hold, ifc.busy, ifc.done, ifc.err, ifc.state_dbg};
  endfunction

  initial begin
    int we0;
    sys_res_n = 1'b0;
    ifc.start = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data = 8'h00;
    repeat (3) cycle();
    check("reset_values", reset_view(), 64'd0);
    sys_res_n = 1'b1;
    cycle();

    // single word, good then bad checksum
    payload = {32'h12345678};
    load("one_good", 0, 1'b0, 1'b0);
    payload = {32'h12345678};
    load("one_badsum", 0, 1'b1, 1'b0);

    bad_length("len_zero", 8'h00, 8'h00);
    bad_length("len_8193", 8'h01, 8'h20);

    // two words with random valid gaps
    payload = {32'h44332211, 32'hDDCCBBAA};
    load("two_gaps", 4, 1'b0, 1'b0);

    // full-size image with stray start pulses
    payload.delete();
    for (int i = 0; i < 8192; i++) payload.push_back($urandom());
    load("full", 0, 1'b0, 1'b1);
    check("full_last_addr", {51'd0, last_addr}, 64'h1FFF);

    // reset in the middle of the second word
    we0 = we_cnt;
    start_session();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    exp_q.push_back({13'd0, 32'hA1B2C3D4});
    send_byte(8'hD4, 0, 1'b0);
    send_byte(8'hC3, 0, 1'b0);
    send_byte(8'hB2, 0, 1'b0);
    send_byte(8'hA1, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    sys_res_n = 1'b0;
    #1;
    check("abort_reset_values", reset_view(), 64'd0);
    cycle();
    cycle();
    check("abort_reset_hold", reset_view(), 64'd0);
    sys_res_n = 1'b1;
    cycle();
    check("abort_we_cnt", 64'(we_cnt - we0), 64'd1);

    payload = {32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF};
    load("after_abort", 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
